// File: rtl/morra_pkg.sv
// Shared constants for the Morra match driver: game codes, FSM states, LFSR tap mask.
package morra_pkg;

  localparam logic [1:0] NO_MOVE  = 2'b00;
  localparam logic [1:0] ROCK     = 2'b01;
  localparam logic [1:0] PAPER    = 2'b10;
  localparam logic [1:0] SCISSORS = 2'b11;

  localparam logic [1:0] INVALID = 2'b00;
  localparam logic [1:0] PLAYER1 = 2'b01;
  localparam logic [1:0] PLAYER2 = 2'b10;
  localparam logic [1:0] NONE    = 2'b11;

  localparam logic [1:0] NOT_ENDED = 2'b00;
  localparam logic [1:0] P1_WINNER = 2'b01;
  localparam logic [1:0] P2_WINNER = 2'b10;
  localparam logic [1:0] DRAW      = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StPlay  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Right-shift Galois toggle mask for x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_MASK = 8'hB8;
  localparam logic [7:0] LFSR_INIT = 8'h01;
  localparam logic [4:0] MAX_PLAYS = 5'd31;
  localparam logic [3:0] MAX_WINS  = 4'd15;

  function automatic logic [1:0] legal_move(input logic [1:0] raw, input logic allow_nomove);
    if (!allow_nomove && raw == NO_MOVE) begin
      return ROCK;
    end
    return raw;
  endfunction

endpackage

// File: rtl/morra_lfsr8.sv
// 8-bit right-shifting Galois LFSR with seed load; a zero seed is forced to 8'h01.
module morra_lfsr8 import morra_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 8'h00) ? LFSR_INIT : seed;
    end else if (step) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/morra_match_driver.sv
// Drives one Morra match against the game block: config cycle, pseudo-random moves,
// win/play bookkeeping, and completion on a winner or after 31 plays.
module morra_match_driver import morra_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] cfg_len,
  input  logic [7:0] seed_p1,
  input  logic [7:0] seed_p2,
  input  logic       allow_nomove,
  output logic       INIZIA,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic       timeout,
  output logic [3:0] p1_wins,
  output logic [3:0] p2_wins,
  output logic [4:0] plays_sent
);

  state_e     state_q, state_d;
  logic       inizia_q, inizia_d;
  logic [1:0] primo_q, primo_d;
  logic [1:0] secondo_q, secondo_d;
  logic [1:0] result_q, result_d;
  logic       timeout_q, timeout_d;
  logic [3:0] p1_wins_q, p1_wins_d;
  logic [3:0] p2_wins_q, p2_wins_d;
  logic [4:0] plays_q, plays_d;
  logic       lfsr_load, lfsr_step;
  logic [7:0] lfsr_p1, lfsr_p2;

  morra_lfsr8 u_lfsr_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed_p1),
    .value (lfsr_p1)
  );

  morra_lfsr8 u_lfsr_p2 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed_p2),
    .value (lfsr_p2)
  );

  // Game outputs are next-state values registered at the edge that enters each cycle.
  always_comb begin
    state_d   = state_q;
    inizia_d  = 1'b0;
    primo_d   = NO_MOVE;
    secondo_d = NO_MOVE;
    result_d  = result_q;
    timeout_d = timeout_q;
    p1_wins_d = p1_wins_q;
    p2_wins_d = p2_wins_q;
    plays_d   = plays_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSetup;
          inizia_d  = 1'b1;
          primo_d   = cfg_len[3:2];
          secondo_d = cfg_len[1:0];
          lfsr_load = 1'b1;
          result_d  = NOT_ENDED;
          timeout_d = 1'b0;
          p1_wins_d = '0;
          p2_wins_d = '0;
          plays_d   = '0;
        end
      end
      StSetup: begin
        state_d   = StPlay;
        primo_d   = legal_move(lfsr_p1[1:0], allow_nomove);
        secondo_d = legal_move(lfsr_p2[1:0], allow_nomove);
        lfsr_step = 1'b1;
      end
      StPlay: begin
        if (plays_q != MAX_PLAYS) begin
          plays_d = plays_q + 5'd1;
        end
        if (MANCHE == PLAYER1 && p1_wins_q != MAX_WINS) begin
          p1_wins_d = p1_wins_q + 4'd1;
        end
        if (MANCHE == PLAYER2 && p2_wins_q != MAX_WINS) begin
          p2_wins_d = p2_wins_q + 4'd1;
        end
        if (PARTITA != NOT_ENDED) begin
          state_d  = StDone;
          result_d = PARTITA;
        end else if (plays_d == MAX_PLAYS) begin
          state_d   = StDone;
          result_d  = NOT_ENDED;
          timeout_d = 1'b1;
        end else begin
          primo_d   = legal_move(lfsr_p1[1:0], allow_nomove);
          secondo_d = legal_move(lfsr_p2[1:0], allow_nomove);
          lfsr_step = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      inizia_q  <= 1'b0;
      primo_q   <= NO_MOVE;
      secondo_q <= NO_MOVE;
      result_q  <= NOT_ENDED;
      timeout_q <= 1'b0;
      p1_wins_q <= '0;
      p2_wins_q <= '0;
      plays_q   <= '0;
    end else begin
      state_q   <= state_d;
      inizia_q  <= inizia_d;
      primo_q   <= primo_d;
      secondo_q <= secondo_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      p1_wins_q <= p1_wins_d;
      p2_wins_q <= p2_wins_d;
      plays_q   <= plays_d;
    end
  end

  assign INIZIA     = inizia_q;
  assign PRIMO      = primo_q;
  assign SECONDO    = secondo_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign result     = result_q;
  assign timeout    = timeout_q;
  assign p1_wins    = p1_wins_q;
  assign p2_wins    = p2_wins_q;
  assign plays_sent = plays_q;

endmodule

// File: tb/tb_morra_match_driver.sv
// Self-checking bench for morra_match_driver: stub game plus a behavioural match model.
module tb_morra_match_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cfg_len = 4'h0;
  logic [7:0] seed_p1 = 8'h00;
  logic [7:0] seed_p2 = 8'h00;
  logic       allow_nomove = 1'b1;
  logic       inizia;
  logic [1:0] primo, secondo;
  logic [1:0] manche = 2'b00;
  logic [1:0] partita = 2'b00;
  logic       busy, done, timeout;
  logic [1:0] result;
  logic [3:0] p1_wins, p2_wins;
  logic [4:0] plays_sent;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] poly_mask;
  logic [1:0] manche_seq [0:31];

  morra_match_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_len      (cfg_len),
    .seed_p1      (seed_p1),
    .seed_p2      (seed_p2),
    .allow_nomove (allow_nomove),
    .INIZIA       (inizia),
    .PRIMO        (primo),
    .SECONDO      (secondo),
    .MANCHE       (manche),
    .PARTITA      (partita),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .timeout      (timeout),
    .p1_wins      (p1_wins),
    .p2_wins      (p2_wins),
    .plays_sent   (plays_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One step of the polynomial's right-shifting Galois form.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ poly_mask) : (v >> 1);
  endfunction

  function automatic logic [1:0] model_move(input logic [1:0] raw, input logic anm);
    return (!anm && raw == 2'b00) ? 2'b01 : raw;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_inizia"}, inizia, 0);
    check_eq({tag, "_primo"}, primo, 0);
    check_eq({tag, "_secondo"}, secondo, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_result"}, result, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_p1"}, p1_wins, 0);
    check_eq({tag, "_p2"}, p2_wins, 0);
    check_eq({tag, "_plays"}, plays_sent, 0);
  endtask

  // end_cyc = PLAY cycle on which the stub reports end_val; 0 or >31 means never.
  task automatic run_match(input logic [7:0] s1, input logic [7:0] s2, input logic [3:0] cfg,
                           input logic anm, input int end_cyc, input logic [1:0] end_val,
                           input bit hold_start, input bit pulse_start);
    logic [7:0] l1, l2;
    int plays, w1, w2, exp_res, exp_to, k;
    bit ended;
    plays = 0; w1 = 0; w2 = 0; exp_res = 0; exp_to = 0; k = 0; ended = 0;
    l1 = (s1 == 8'h00) ? 8'h01 : s1;
    l2 = (s2 == 8'h00) ? 8'h01 : s2;
    @(negedge clk);
    seed_p1 = s1; seed_p2 = s2; cfg_len = cfg; allow_nomove = anm;
    start = 1'b1; manche = 2'b00; partita = 2'b00;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    check_eq("setup_inizia", inizia, 1);
    check_eq("setup_primo", primo, cfg[3:2]);
    check_eq("setup_secondo", secondo, cfg[1:0]);
    check_eq("setup_busy", busy, 1);
    check_eq("setup_done", done, 0);
    // Seeds must already be captured; scramble them to prove it.
    seed_p1 = 8'($urandom); seed_p2 = 8'($urandom);
    while (!ended) begin
      @(negedge clk);
      k++;
      check_eq("play_inizia", inizia, 0);
      check_eq("play_primo", primo, model_move(l1[1:0], anm));
      check_eq("play_secondo", secondo, model_move(l2[1:0], anm));
      check_eq("play_busy", busy, 1);
      check_eq("play_done", done, 0);
      if (!anm) begin
        check_eq("nomove_p1", (primo != 2'b00), 1);
        check_eq("nomove_p2", (secondo != 2'b00), 1);
      end
      l1 = lfsr_next(l1);
      l2 = lfsr_next(l2);
      manche = manche_seq[k-1];
      partita = (k == end_cyc) ? end_val : 2'b00;
      start = (pulse_start && k == 2) || hold_start;
      if (manche == 2'b01 && w1 < 15) w1++;
      if (manche == 2'b10 && w2 < 15) w2++;
      if (plays < 31) plays++;
      if (partita != 2'b00) begin
        ended = 1; exp_res = int'(partita);
      end else if (plays == 31) begin
        ended = 1; exp_to = 1; exp_res = 0;
      end
    end
    @(negedge clk);
    manche = 2'b00; partita = 2'b00; start = 1'b0;
    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 1);
    check_eq("done_inizia", inizia, 0);
    check_eq("done_primo", primo, 0);
    check_eq("done_secondo", secondo, 0);
    check_eq("done_result", result, exp_res);
    check_eq("done_timeout", timeout, exp_to);
    check_eq("done_p1_wins", p1_wins, w1);
    check_eq("done_p2_wins", p2_wins, w2);
    check_eq("done_plays", plays_sent, plays);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("idle_done", done, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_result", result, exp_res);
      check_eq("idle_timeout", timeout, exp_to);
      check_eq("idle_plays", plays_sent, plays);
      check_eq("idle_p1_wins", p1_wins, w1);
    end
  endtask

  initial begin
    int taps[4];
    taps = '{8, 6, 5, 4};
    poly_mask = 8'h00;
    foreach (taps[i]) poly_mask[taps[i]-1] = 1'b1;

    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Winner on 3rd PLAY cycle.
    for (int i = 0; i < 32; i++) manche_seq[i] = 2'b11;
    run_match(8'h5A, 8'hC3, 4'b1001, 1'b1, 3, 2'b01, 0, 0);

    // Mixed manches, P2 declared winner on 4th cycle.
    manche_seq[0] = 2'b01; manche_seq[1] = 2'b10;
    manche_seq[2] = 2'b01; manche_seq[3] = 2'b11;
    run_match(8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 4, 2'b10, 0, 0);

    // Never-ending game: timeout after 31 plays, win counters saturate.
    for (int i = 0; i < 32; i++) manche_seq[i] = 2'b01;
    run_match(8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 0, 2'b00, 0, 0);

    // Zero seeds, no-move suppression.
    for (int i = 0; i < 32; i++) manche_seq[i] = 2'($urandom);
    run_match(8'h00, 8'h00, 4'($urandom), 1'b0, 0, 2'b00, 0, 0);

    // start held high for a whole match, then start pulsed mid-play.
    run_match(8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 6, 2'b11, 1, 0);
    run_match(8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 5, 2'b01, 0, 1);

    // Reset mid-play: immediate reset values, no done pulse, then a normal match.
    @(negedge clk);
    seed_p1 = 8'h37; seed_p2 = 8'h91; cfg_len = 4'hF; start = 1'b1;
    manche = 2'b01; partita = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_no_done", done, 0);
      check_eq("rst_busy", busy, 0);
    end
    manche = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) manche_seq[i] = 2'($urandom);
    run_match(8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 7, 2'b10, 0, 0);

    // Randomized matches.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) manche_seq[i] = 2'($urandom);
      run_match(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
                int'($urandom_range(1, 40)), 2'($urandom_range(1, 3)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
